// File: rtl/weight_fetch_streamer_if.sv
// Command, weight-memory and weight-stream signals of weight_fetch_streamer.
// master = streamer side, slave = memory/controller/MAC environment.
interface weight_fetch_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  num_words;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_last;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] checksum;

  modport master (
    input  start, base_addr, num_words, mem_data, w_ready,
    output busy, done, mem_addr, w_valid, w_data, w_last, checksum
  );

  modport slave (
    output start, base_addr, num_words, mem_data, w_ready,
    input  busy, done, mem_addr, w_valid, w_data, w_last, checksum
  );
endinterface

// File: rtl/weight_fetch_streamer.sv
// Streams num_words weights from base_addr as registered valid/ready beats; first beat 2 cycles after start,
// one beat/cycle, holds under w_ready=0. Block checksum enabled by WEIGHT_CHECKSUM_EN.
module weight_fetch_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input logic                     clk,
  input logic                     rst,
  weight_fetch_streamer_if.master bus
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
  logic [LEN_WIDTH-1:0]  remaining, remaining_nxt;
  logic                  w_valid_q, w_valid_nxt;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_nxt;
  logic                  w_last_q, w_last_nxt;
  logic                  done_q, done_nxt;
  logic                  start_ok, fire, load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      remaining <= remaining_nxt;
      w_valid_q <= w_valid_nxt;
      w_data_q  <= w_data_nxt;
      w_last_q  <= w_last_nxt;
      done_q    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    w_valid_nxt   = w_valid_q;
    w_data_nxt    = w_data_q;
    w_last_nxt    = w_last_q;
    done_nxt      = 1'b0;
    start_ok      = (state == IDLE) && bus.start;
    fire          = w_valid_q && bus.w_ready;
    load          = (state == FETCH) && (remaining != '0) && (!w_valid_q || bus.w_ready);

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_words != '0) begin
            state_nxt     = FETCH;
            cur_addr_nxt  = bus.base_addr;
            remaining_nxt = bus.num_words;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      FETCH: begin
        // A refill takes priority; otherwise a consumed beat empties the output register.
        if (load) begin
          w_data_nxt    = bus.mem_data;
          w_valid_nxt   = 1'b1;
          w_last_nxt    = (remaining == LEN_WIDTH'(1));
          cur_addr_nxt  = cur_addr + ADDR_WIDTH'(1);
          remaining_nxt = remaining - LEN_WIDTH'(1);
        end else if (fire) begin
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
        end
        if (fire && w_last_q) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
    endcase
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.mem_addr = cur_addr;
  assign bus.w_valid  = w_valid_q;
  assign bus.w_data   = w_data_q;
  assign bus.w_last   = w_last_q;

`ifdef WEIGHT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (start_ok) begin
      checksum_q <= '0;
    end else if (fire) begin
      checksum_q <= checksum_q + w_data_q;
    end
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_weight_fetch_streamer.sv
// Directed + randomized bench for weight_fetch_streamer against a queue/array reference model.
module tb_weight_fetch_streamer;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_fetch_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  weight_fetch_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [DW-1:0] mem [DEPTH];
  assign bus.mem_data = mem[bus.mem_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_cyc = 0;
  beat_t got[$];

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_addr;
  logic          prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor; also checks that a stalled beat holds its contents.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold", {bus.w_valid, bus.w_last, bus.mem_addr, bus.w_data},
            {1'b1, prev_last, prev_addr, prev_data});
      end
      if (bus.w_valid && bus.w_ready) begin
        got.push_back('{bus.w_data, bus.w_last});
        if (bus.w_last) last_cyc = cyc;
      end
      if (bus.done) done_cnt++;
      prev_stall = bus.w_valid && !bus.w_ready;
      prev_data  = bus.w_data;
      prev_addr  = bus.mem_addr;
      prev_last  = bus.w_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] exp_sum(input int base, input int n);
    logic [DW-1:0] s = '0;
`ifdef WEIGHT_CHECKSUM_EN
    for (int i = 0; i < n; i++) s = s + mem[(base + i) % DEPTH];
`endif
    return s;
  endfunction

  task automatic start_block(input int base, input int n);
    got.delete();
    last_cyc = 0;
    bus.base_addr = AW'(base);
    bus.num_words = LW'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.base_addr = AW'($urandom);
    bus.num_words = LW'($urandom);
  endtask

  // Runs until the done cycle, then checks the received stream against the model.
  task automatic finish_block(input string tag, input int base, input int n, input bit rnd);
    int k = 0;
    int bad = 0;
    while (!bus.done && k < 8 * n + 50) begin
      if (rnd) bus.w_ready = ($urandom_range(0, 3) != 0);
      tick();
      k++;
    end
    bus.w_ready = 1'b1;
    chk({tag, "_done_seen"}, bus.done, 1'b1);
    chk({tag, "_busy_in_done"}, bus.busy, 1'b0);
    chk({tag, "_done_after_last"}, last_cyc, cyc - 1);
    chk({tag, "_beats"}, got.size(), n);
    for (int i = 0; i < got.size() && i < n; i++) begin
      if (got[i].d !== mem[(base + i) % DEPTH] || got[i].l !== (i == n - 1)) bad++;
    end
    chk({tag, "_bad_beats"}, bad, 0);
    chk({tag, "_checksum"}, bus.checksum, exp_sum(base, n));
  endtask

  task automatic run_block(input string tag, input int base, input int n, input bit rnd);
    start_block(base, n);
    finish_block(tag, base, n, rnd);
  endtask

  initial begin
    int b;
    int k;
    int dc;
    logic [DW-1:0] d0;
    logic [AW-1:0] a0;

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    bus.w_ready = 1'b1;
    repeat (3) tick();
    chk("rst_outputs", {bus.busy, bus.done, bus.w_valid, bus.w_last}, 4'b0);
    chk("rst_data_addr", {bus.w_data, bus.mem_addr}, '0);
    chk("rst_checksum", bus.checksum, 0);
    rst = 1'b0;
    tick();

    // Basic block with exact cycle timing.
    start_block('h010, 4);
    chk("basic_t1", {bus.busy, bus.w_valid, bus.mem_addr}, {1'b1, 1'b0, 10'h010});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("basic_beat", {bus.busy, bus.w_valid, bus.w_last, bus.w_data},
          {1'b1, 1'b1, 1'(i == 3), mem['h010 + i]});
      chk("basic_addr", bus.mem_addr, 10'(('h010 + i + 1)));
    end
    tick();
    chk("basic_done", {bus.done, bus.busy, bus.w_valid}, 3'b100);
    chk("basic_stream", got.size(), 4);
    chk("basic_checksum", bus.checksum, exp_sum('h010, 4));
    tick();
    chk("basic_done_pulse", bus.done, 1'b0);

    // Backpressure on the third beat.
    b = $urandom_range(0, DEPTH - 1);
    start_block(b, 8);
    repeat (3) tick();
    bus.w_ready = 1'b0;
    d0 = bus.w_data;
    a0 = bus.mem_addr;
    chk("bp_beat2", d0, mem[(b + 2) % DEPTH]);
    repeat (3) begin
      tick();
      chk("bp_hold", {bus.w_valid, bus.w_data, bus.mem_addr}, {1'b1, d0, a0});
    end
    bus.w_ready = 1'b1;
    finish_block("bp", b, 8, 1'b0);

    run_block("wrap", 'h3FE, 4, 1'b0);

    // Zero-length block.
    start_block($urandom_range(0, DEPTH - 1), 0);
    chk("zero_done", {bus.done, bus.busy}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("zero_idle", {bus.done, bus.busy, bus.w_valid}, 3'b000);
    end
    chk("zero_no_beats", got.size(), 0);

    // Start pulsed mid-block is ignored.
    b = $urandom_range(0, DEPTH - 1);
    start_block(b, 6);
    tick();
    tick();
    bus.start = 1'b1;
    bus.base_addr = AW'(b + 100);
    bus.num_words = LW'(3);
    tick();
    bus.start = 1'b0;
    finish_block("ignored_start", b, 6, 1'b0);

    // Reset mid-block, then a fresh block from address 0.
    start_block('h100, 8);
    k = 0;
    while (got.size() < 2 && k < 20) begin
      tick();
      k++;
    end
    chk("rst_mid_progress", got.size(), 2);
    dc = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_async", {bus.w_valid, bus.busy, bus.w_last, bus.mem_addr}, '0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_mid_no_done", done_cnt, dc);
    chk("rst_mid_idle", {bus.busy, bus.w_valid}, 2'b00);
    run_block("after_reset", 0, 2, 1'b0);

    // Checksum with known words, including wrap of the sum.
    mem['h200] = 32'h0000_0001;
    mem['h201] = 32'h0000_0002;
    mem['h202] = 32'h0000_0003;
    mem['h203] = 32'hFFFF_FFFF;
    run_block("csum", 'h200, 4, 1'b0);
`ifdef WEIGHT_CHECKSUM_EN
    chk("csum_value", bus.checksum, 32'h0000_0005);
`else
    chk("csum_value", bus.checksum, 32'h0);
`endif
    repeat (3) tick();
    chk("csum_stable", bus.checksum, exp_sum('h200, 4));

    // Random back-to-back blocks, each started in the previous done cycle.
    for (int i = 0; i < 8; i++) begin
      run_block("random", $urandom_range(0, DEPTH - 1), $urandom_range(1, 40), 1'b1);
    end

    run_block("full_mem", $urandom_range(0, DEPTH - 1), DEPTH, 1'b0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
